// File: rtl/button_event_gen_if.sv
// rtl/button_event_gen_if.sv - button level in, event pulses and held flags out
interface button_event_gen_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_step;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_held;

    modport master (
        output btn_level,
        input  btn_press, btn_step, btn_release, btn_held
    );

    modport slave (
        input  btn_level,
        output btn_press, btn_step, btn_release, btn_held
    );
endinterface

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced levels to press/step/release pulses; BTN_AUTO_REPEAT_EN enables auto-repeat
module button_event_gen #(
    parameter int NUM_BTN      = 5,
    parameter int TICK_DIV     = 100000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 150,
    parameter int CNT_W        = 10
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    button_event_gen_if.slave    bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam int CNT_MAX = ((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS) - 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] rise, fall;
    logic [1:0]         state_q [NUM_BTN];
    logic [1:0]         state_d [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] step_q, step_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] held_q, held_d;

    // Free-running shared tick; button activity never restarts it.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    assign rise = bus.btn_level & ~btn_prev_q;
    assign fall = ~bus.btn_level & btn_prev_q;

    always_comb begin
        press_d   = '0;
        step_d    = '0;
        release_d = '0;
        held_d    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = S_HOLD;
                        cnt_d[i]   = '0;
                        press_d[i] = 1'b1;
                        step_d[i]  = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (fall[i]) begin
                        state_d[i]   = S_IDLE;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (tick) begin
`ifdef BTN_AUTO_REPEAT_EN
                        if (cnt_q[i] == HOLD_LAST) begin
                            state_d[i] = S_REPEAT;
                            cnt_d[i]   = '0;
                            step_d[i]  = 1'b1;
                        end else
`endif
                        if (cnt_q[i] != CNT_SAT) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
`ifdef BTN_AUTO_REPEAT_EN
                S_REPEAT: begin
                    // Release takes priority over a repeat falling due this cycle.
                    if (fall[i]) begin
                        state_d[i]   = S_IDLE;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else if (tick) begin
                        if (cnt_q[i] == REPEAT_LAST) begin
                            cnt_d[i]  = '0;
                            step_d[i] = 1'b1;
                        end else if (cnt_q[i] != CNT_SAT) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] != S_IDLE);
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            tick_cnt_q <= '0;
            btn_prev_q <= bus.btn_level;
            press_q    <= '0;
            step_q     <= '0;
            release_q  <= '0;
            held_q     <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            btn_prev_q <= bus.btn_level;
            press_q    <= press_d;
            step_q     <= step_d;
            release_q  <= release_d;
            held_q     <= held_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.btn_press   = press_q;
    assign bus.btn_step    = step_q;
    assign bus.btn_release = release_q;
    assign bus.btn_held    = held_q;
endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - randomized bench for button_event_gen against an event-history model
module tb_button_event_gen;
    localparam int N      = 5;
    localparam int DIV    = 4;
    localparam int HOLD   = 3;
    localparam int REPEAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] level = '0;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_phase;
    bit         m_held  [N];
    int         m_ticks [N];
    logic [N-1:0] m_prev;
    logic [N-1:0] e_press, e_step, e_release, e_held;

    button_event_gen_if #(.NUM_BTN(N)) bif ();
    assign bif.btn_level = level;

    button_event_gen #(
        .NUM_BTN(N), .TICK_DIV(DIV), .HOLD_TICKS(HOLD),
        .REPEAT_TICKS(REPEAT), .CNT_W(4)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Step due once the held-tick count reaches HOLD, then every REPEAT ticks after it.
    function automatic bit step_due(input int ticks);
`ifdef BTN_AUTO_REPEAT_EN
        return (ticks == HOLD) || (ticks > HOLD && ((ticks - HOLD) % REPEAT) == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit repeat_due_next(input int b);
        return m_held[b] && (m_phase == DIV - 1) && step_due(m_ticks[b] + 1)
               && (m_ticks[b] + 1 > HOLD);
    endfunction

    task automatic model_edge();
        bit tk;
        e_press = '0; e_step = '0; e_release = '0;
        if (rst) begin
            m_phase = 0;
            m_prev  = level;
            for (int i = 0; i < N; i++) begin
                m_held[i]  = 1'b0;
                m_ticks[i] = 0;
            end
        end else begin
            tk      = (m_phase == DIV - 1);
            m_phase = (m_phase + 1) % DIV;
            for (int i = 0; i < N; i++) begin
                if (!m_held[i] && level[i] && !m_prev[i]) begin
                    m_held[i]  = 1'b1;
                    m_ticks[i] = 0;
                    e_press[i] = 1'b1;
                    e_step[i]  = 1'b1;
                end else if (m_held[i] && !level[i] && m_prev[i]) begin
                    m_held[i]    = 1'b0;
                    e_release[i] = 1'b1;
                end else if (m_held[i] && tk) begin
                    m_ticks[i]++;
                    if (step_due(m_ticks[i])) e_step[i] = 1'b1;
                end
            end
            m_prev = level;
        end
        for (int i = 0; i < N; i++) e_held[i] = m_held[i];
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] lvl);
        rst   = r;
        level = lvl;
        @(posedge clk);
        model_edge();
        #1;
        check("press",   32'(bif.btn_press),   32'(e_press));
        check("step",    32'(bif.btn_step),    32'(e_step));
        check("release", 32'(bif.btn_release), 32'(e_release));
        check("held",    32'(bif.btn_held),    32'(e_held));
    endtask

    initial begin
        logic [N-1:0] lv;
        int           waited;
        m_phase = 0;
        m_prev  = '0;
        for (int i = 0; i < N; i++) begin m_held[i] = 0; m_ticks[i] = 0; end
        #1;

        // Button 0 held through reset must not produce a press.
        for (int k = 0; k < 3; k++) cycle(1'b1, 5'b00001);
        for (int k = 0; k < 20; k++) cycle(1'b0, 5'b00001);

        // Long hold on button 1 spanning several repeats.
        for (int k = 0; k < 40; k++) cycle(1'b0, 5'b00011);
        cycle(1'b0, 5'b00001);
        for (int k = 0; k < 4; k++) cycle(1'b0, 5'b00000);

        // Release button 2 on the very edge a repeat would fire.
        cycle(1'b0, 5'b00100);
        waited = 0;
        while (!repeat_due_next(2) && waited < 60) begin
            cycle(1'b0, 5'b00100);
            waited++;
        end
`ifdef BTN_AUTO_REPEAT_EN
        check("repeat_due_found", 32'(waited < 60), 32'd1);
`endif
        cycle(1'b0, 5'b00000);
        cycle(1'b0, 5'b00000);

        // Simultaneous presses.
        cycle(1'b0, 5'b10101);
        for (int k = 0; k < 30; k++) cycle(1'b0, 5'b10101);
        cycle(1'b0, 5'b00000);
        cycle(1'b0, 5'b00000);

        // Long hold of button 0 (single step when auto-repeat is off).
        for (int k = 0; k < 100; k++) cycle(1'b0, 5'b00001);
        cycle(1'b0, 5'b00000);

        // Random level activity with occasional mid-hold resets.
        lv = '0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) lv[b] = ~lv[b];
            cycle(($urandom_range(149) == 0) ? 1'b1 : 1'b0, lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
